// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: fixed-priority next-PC select, one-entry stalled-redirect buffer,
// and a circular return-address stack for JR-return prediction.
module pc_fetch_unit #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h80000180,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4,
  localparam int             CW        = $clog2(RAS_DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StallF,
  input  logic             ExcF,
  input  logic             BranchE,
  input  logic [WIDTH-1:0] BranchTgtE,
  input  logic             JumpD,
  input  logic [WIDTH-1:0] JumpTgtD,
  input  logic             CallD,
  input  logic             RetD,
  input  logic [WIDTH-1:0] RetAddrD,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlusF,
  output logic             RedirectF,
  output logic [CW-1:0]    RasCount
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH-1);

  typedef struct packed {
    logic             vld;
    logic             exc;
    logic [WIDTH-1:0] tgt;
  } pend_t;

  logic [WIDTH-1:0] pcf, pc_n;
  logic             redir, redir_n;
  pend_t            pend, pend_n;

  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras;
  logic [PW-1:0]    tp, tp_inc, tp_dec;
  logic [CW-1:0]    cnt;
  logic             ras_empty, ras_clr, do_push, do_pop, do_repl;
  logic [WIDTH-1:0] top;

  assign PCF       = pcf;
  assign PCPlusF   = pcf + WIDTH'(INC);
  assign RedirectF = redir;
  assign RasCount  = cnt;

  assign ras_empty = (cnt == '0);
  assign top       = ras[tp];
  assign tp_inc    = (tp == LAST) ? '0 : tp + PW'(1);
  assign tp_dec    = (tp == '0) ? LAST : tp - PW'(1);

  always_comb begin
    pc_n    = pcf;
    redir_n = 1'b0;
    pend_n  = pend;
    ras_clr = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    if (StallF) begin
      // An exception already buffered is never displaced by a later branch
      if (ExcF) begin
        pend_n  = '{vld: 1'b1, exc: 1'b1, tgt: EXC_VEC};
        ras_clr = 1'b1;
      end else if (BranchE && !(pend.vld && pend.exc)) begin
        pend_n = '{vld: 1'b1, exc: 1'b0, tgt: BranchTgtE};
      end
    end else begin
      pend_n  = '0;
      redir_n = 1'b1;
      if (ExcF) begin
        pc_n    = EXC_VEC;
        ras_clr = 1'b1;
      end else if (BranchE) begin
        pc_n = BranchTgtE;
      end else if (pend.vld) begin
        pc_n = pend.tgt;
      end else if (RetD) begin
        pc_n = ras_empty ? JumpTgtD : top;
        if (CallD) begin
          do_push = ras_empty;
          do_repl = !ras_empty;
        end else begin
          do_pop = !ras_empty;
        end
      end else begin
        if (JumpD) begin
          pc_n = JumpTgtD;
        end else begin
          pc_n    = PCPlusF;
          redir_n = 1'b0;
        end
        do_push = CallD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pcf   <= RESET_VEC;
      redir <= 1'b0;
      pend  <= '0;
    end else begin
      pcf   <= pc_n;
      redir <= redir_n;
      pend  <= pend_n;
    end
  end

  // Push on a full stack advances past the oldest entry; count saturates
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ras <= '0;
      tp  <= '0;
      cnt <= '0;
    end else if (ras_clr) begin
      tp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      tp          <= tp_inc;
      ras[tp_inc] <= RetAddrD;
      if (cnt != FULL) cnt <= cnt + CW'(1);
    end else if (do_pop) begin
      tp  <= tp_dec;
      cnt <= cnt - CW'(1);
    end else if (do_repl) begin
      ras[tp] <= RetAddrD;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RVEC = 32'h0;
  localparam logic [31:0] EVEC = 32'h80000180;
  localparam int DEPTH = 4;

  logic        CLK, RST, StallF, ExcF, BranchE, JumpD, CallD, RetD;
  logic [31:0] BranchTgtE, JumpTgtD, RetAddrD, PCF, PCPlusF;
  logic        RedirectF;
  logic [2:0]  RasCount;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] mpc;
  logic        mredir, mpv, mpexc;
  logic [31:0] mptgt;
  logic [31:0] mras[$];

  pc_fetch_unit dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .ExcF(ExcF), .BranchE(BranchE),
    .BranchTgtE(BranchTgtE), .JumpD(JumpD), .JumpTgtD(JumpTgtD), .CallD(CallD),
    .RetD(RetD), .RetAddrD(RetAddrD), .PCF(PCF), .PCPlusF(PCPlusF),
    .RedirectF(RedirectF), .RasCount(RasCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    StallF = 0; ExcF = 0; BranchE = 0; JumpD = 0; CallD = 0; RetD = 0;
    BranchTgtE = '0; JumpTgtD = '0; RetAddrD = '0;
  endtask

  task automatic model_reset();
    mpc = RVEC; mredir = 0; mpv = 0; mpexc = 0; mptgt = '0; mras.delete();
  endtask

  // Reference next-state straight from the priority rules; RAS is a bounded queue
  task automatic model_edge();
    if (StallF) begin
      mredir = 0;
      if (ExcF) begin
        mpv = 1; mpexc = 1; mptgt = EVEC; mras.delete();
      end else if (BranchE && !(mpv && mpexc)) begin
        mpv = 1; mpexc = 0; mptgt = BranchTgtE;
      end
    end else if (ExcF) begin
      mpc = EVEC; mredir = 1; mpv = 0; mpexc = 0; mras.delete();
    end else if (BranchE) begin
      mpc = BranchTgtE; mredir = 1; mpv = 0; mpexc = 0;
    end else if (mpv) begin
      mpc = mptgt; mredir = 1; mpv = 0; mpexc = 0;
    end else if (RetD) begin
      mredir = 1;
      if (mras.size() > 0) begin
        mpc = mras[mras.size()-1];
        if (CallD) mras[mras.size()-1] = RetAddrD;
        else void'(mras.pop_back());
      end else begin
        mpc = JumpTgtD;
        if (CallD) mras.push_back(RetAddrD);
      end
    end else begin
      if (JumpD) begin mpc = JumpTgtD; mredir = 1; end
      else begin mpc = mpc + 32'd4; mredir = 0; end
      if (CallD) begin
        mras.push_back(RetAddrD);
        if (mras.size() > DEPTH) void'(mras.pop_front());
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 0; idle(); model_reset();
    #12;
    total++; if (PCF !== RVEC) begin bad++; $display("FAIL reset_pcf got=%h exp=%h", PCF, RVEC); end
    total++; if (RedirectF !== 1'b0) begin bad++; $display("FAIL reset_redir got=%b exp=0", RedirectF); end
    total++; if (RasCount !== 3'd0) begin bad++; $display("FAIL reset_ras got=%0d exp=0", RasCount); end
    RST = 1;
    @(posedge CLK); #1;  // first edge after release: sequential step
    model_edge();
    for (int i = 2; i <= 3; i++) begin
      tick();
      total++; if (PCF !== 32'(4*i)) begin bad++; $display("FAIL free_run got=%h exp=%h", PCF, 32'(4*i)); end
      total++; if (RedirectF !== 1'b0 || RasCount !== 3'd0) begin
        bad++; $display("FAIL free_run_flags redir=%b cnt=%0d exp 0/0", RedirectF, RasCount); end
    end
  endtask

  task automatic test_stall_branch();
    logic [31:0] held;
    held = PCF;
    StallF = 1; BranchE = 1; BranchTgtE = 32'h100;
    tick();
    BranchE = 0;
    tick();
    total++; if (PCF !== held || RedirectF !== 1'b0) begin
      bad++; $display("FAIL stall_hold got=%h/%b exp=%h/0", PCF, RedirectF, held); end
    StallF = 0;
    tick();
    total++; if (PCF !== 32'h100 || RedirectF !== 1'b1) begin
      bad++; $display("FAIL stall_branch_release got=%h/%b exp=100/1", PCF, RedirectF); end
    tick();
    total++; if (PCF !== 32'h104 || RedirectF !== 1'b0) begin
      bad++; $display("FAIL after_release got=%h/%b exp=104/0", PCF, RedirectF); end
  endtask

  task automatic test_stall_exc();
    CallD = 1; RetAddrD = 32'h44;
    tick();
    CallD = 0;
    total++; if (RasCount !== 3'd1) begin bad++; $display("FAIL pre_exc_push got=%0d exp=1", RasCount); end
    StallF = 1; BranchE = 1; BranchTgtE = 32'h200;
    tick();
    BranchE = 0; ExcF = 1;
    tick();
    ExcF = 0; BranchE = 1; BranchTgtE = 32'h300;  // must not displace buffered exception
    tick();
    StallF = 0; BranchE = 0;
    tick();
    total++; if (PCF !== EVEC || RedirectF !== 1'b1) begin
      bad++; $display("FAIL stall_exc_release got=%h/%b exp=%h/1", PCF, RedirectF, EVEC); end
    total++; if (RasCount !== 3'd0) begin bad++; $display("FAIL stall_exc_ras got=%0d exp=0", RasCount); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_t [5];
    exp_t = '{32'h50, 32'h40, 32'h30, 32'h20, 32'hABC0};
    for (int i = 1; i <= 5; i++) begin
      CallD = 1; RetAddrD = 32'(i*16);
      tick();
    end
    CallD = 0;
    total++; if (RasCount !== 3'd4) begin bad++; $display("FAIL ras_sat got=%0d exp=4", RasCount); end
    RetD = 1; JumpTgtD = 32'hABC0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (PCF !== exp_t[i] || RedirectF !== 1'b1) begin
        bad++; $display("FAIL ras_pop%0d got=%h/%b exp=%h/1", i, PCF, RedirectF, exp_t[i]); end
      total++; if (RasCount !== 3'((i < 4) ? 3 - i : 0)) begin
        bad++; $display("FAIL ras_cnt%0d got=%0d exp=%0d", i, RasCount, (i < 4) ? 3 - i : 0); end
    end
    // call+return together: predict old top, replace it in place
    RetD = 0; CallD = 1; RetAddrD = 32'h700;
    tick();
    RetD = 1; RetAddrD = 32'h800;
    tick();
    total++; if (PCF !== 32'h700 || RasCount !== 3'd1) begin
      bad++; $display("FAIL call_ret got=%h/%0d exp=700/1", PCF, RasCount); end
    CallD = 0;
    tick();
    total++; if (PCF !== 32'h800 || RasCount !== 3'd0) begin
      bad++; $display("FAIL call_ret_pop got=%h/%0d exp=800/0", PCF, RasCount); end
    RetD = 0;
  endtask

  task automatic test_priority();
    CallD = 1; RetAddrD = 32'h90;
    tick();
    CallD = 0; ExcF = 1; BranchE = 1; BranchTgtE = 32'h400; JumpD = 1; JumpTgtD = 32'h500;
    tick();
    total++; if (PCF !== EVEC || RedirectF !== 1'b1 || RasCount !== 3'd0) begin
      bad++; $display("FAIL prio_exc got=%h/%b/%0d exp=%h/1/0", PCF, RedirectF, RasCount, EVEC); end
    ExcF = 0; CallD = 1; RetAddrD = 32'h94;
    tick();
    total++; if (PCF !== 32'h400 || RasCount !== 3'd0) begin
      bad++; $display("FAIL prio_branch got=%h/%0d exp=400/0", PCF, RasCount); end
    idle();
  endtask

  task automatic test_wrap();
    JumpD = 1; JumpTgtD = 32'hFFFFFFFC;
    tick();
    JumpD = 0;
    total++; if (PCPlusF !== 32'h0) begin bad++; $display("FAIL wrap_plus got=%h exp=0", PCPlusF); end
    tick();
    total++; if (PCF !== 32'h0 || RedirectF !== 1'b0) begin
      bad++; $display("FAIL wrap_pc got=%h/%b exp=0/0", PCF, RedirectF); end
  endtask

  task automatic test_reset_mid();
    CallD = 1; RetAddrD = 32'h60;
    tick();
    CallD = 0; StallF = 1; BranchE = 1; BranchTgtE = 32'h900;
    tick();
    BranchE = 0;
    #1 RST = 0;
    #1;
    total++; if (PCF !== RVEC || RasCount !== 3'd0 || RedirectF !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%h/%0d/%b exp=%h/0/0", PCF, RasCount, RedirectF, RVEC); end
    model_reset();
    #1 RST = 1; StallF = 0;
    tick();
    total++; if (PCF !== RVEC + 32'd4 || RedirectF !== 1'b0) begin
      bad++; $display("FAIL post_reset got=%h/%b exp=%h/0", PCF, RedirectF, RVEC + 32'd4); end
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = bad;
    for (int i = 0; i < 400; i++) begin
      StallF  = ($urandom_range(0, 3) == 0);
      ExcF    = ($urandom_range(0, 19) == 0);
      BranchE = ($urandom_range(0, 9) == 0);
      JumpD   = ($urandom_range(0, 6) == 0);
      CallD   = ($urandom_range(0, 4) == 0);
      RetD    = ($urandom_range(0, 4) == 0);
      BranchTgtE = {$urandom()} & 32'hFFFF_FFFC;
      JumpTgtD   = {$urandom()} & 32'hFFFF_FFFC;
      RetAddrD   = {$urandom()} & 32'hFFFF_FFFC;
      tick();
      total++; if (PCF !== mpc || PCPlusF !== mpc + 32'd4) begin
        bad++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", i, PCF, PCPlusF, mpc); end
      total++; if (RedirectF !== mredir || RasCount !== 3'(mras.size())) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b/%0d exp=%b/%0d", i, RedirectF, RasCount, mredir, mras.size()); end
      if (bad - errs_before > 10) break;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_stall_exc();
    idle();
    test_ras();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
